hazard_unit_mc: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core and the successor to the single-cycle-memory hazard unit. It keeps E-stage and D-stage forwarding, load-use stalls and branch stalls. It adds three things:
- variable-latency data-memory wait handling (ready handshake);
- a multi-cycle multiply/divide busy tracker with structural stalls;
- saturating per-cause stall statistics counters.

---
 rtl/hazard_pkg.sv | 29 ++
 rtl/hz_sat_counter.sv | 32 +++
 rtl/hazard_unit_mc.sv | 151 +++++++++++++++
 tb/tb_hazard_unit_mc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types and defaults for the multi-cycle hazard unit
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    CAUSE_LW  = 2'd0,
    CAUSE_BR  = 2'd1,
    CAUSE_MD  = 2'd2,
    CAUSE_MEM = 2'd3
  } stall_cause_e;

  localparam int C_REG_AW     = 5;
  localparam int C_MD_LATENCY = 4;
  localparam int C_CNT_W      = 16;
  localparam int C_NUM_CAUSES = 4;

endpackage

`default_nettype wire

// File: rtl/hz_sat_counter.sv
// ============================================================================
// hz_sat_counter : saturating event counter with synchronous clear
// Rev 1.0
// ============================================================================
`default_nettype none

module hz_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Clear wins over increment; the count holds once it reaches all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_unit_mc.sv
// ============================================================================
// hazard_unit_mc : forwarding, stall and flush control for the 5-stage core
// with memory wait, mult/div busy tracking and stall statistics. Rev 1.0
// ============================================================================
`default_nettype none

module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW     = C_REG_AW,
  parameter int MD_LATENCY = C_MD_LATENCY,
  parameter int CNT_W      = C_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branchD,
  input  logic              mdopD,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              mdstartE,
  input  logic              memreqM,
  input  logic              dmem_ready,
  input  logic              stat_clr,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushE,
  output logic              flushW,
  output logic              md_busy,
  output logic [CNT_W-1:0]  lw_cnt,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  md_cnt_stat,
  output logic [CNT_W-1:0]  mem_cnt
);

  localparam int              MD_W      = $clog2(MD_LATENCY + 1);
  localparam logic [MD_W-1:0] C_MD_LOAD = MD_W'(MD_LATENCY);

  function automatic fwd_sel_e fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wr_m,
    input logic              we_m,
    input logic [REG_AW-1:0] wr_w,
    input logic              we_w
  );
    if ((src != '0) && we_m && (src == wr_m)) return FWD_MEM;
    if ((src != '0) && we_w && (src == wr_w)) return FWD_WB;
    return FWD_RF;
  endfunction

  logic                    w_lwstall;
  logic                    w_brstall;
  logic                    w_memstall;
  logic                    w_mdstall;
  logic [C_NUM_CAUSES-1:0] w_raw;
  logic [CNT_W-1:0]        w_cnt [C_NUM_CAUSES];
  logic [MD_W-1:0]         r_md_q;

  assign forwardAE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardBE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;

  assign w_lwstall  = memtoregE && (rtE != '0) && ((rsD == rtE) || (rtD == rtE));
  assign w_brstall  = branchD &&
                      ((regwriteE && (writeregE != '0) &&
                        ((writeregE == rsD) || (writeregE == rtD))) ||
                       (memtoregM && (writeregM != '0) &&
                        ((writeregM == rsD) || (writeregM == rtD))));
  assign w_memstall = memreqM && !dmem_ready;
  assign w_mdstall  = mdopD && (md_busy || mdstartE);

  // A memory wait freezes the whole pipe and bubbles W; other hazards bubble E.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (!reset) begin
      if (w_memstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (w_lwstall || w_brstall || w_mdstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // The unit keeps counting while the pipe is frozen; a held issue does not reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_q <= '0;
    end else if (mdstartE && !stallE) begin
      r_md_q <= C_MD_LOAD;
    end else if (r_md_q != '0) begin
      r_md_q <= r_md_q - 1'b1;
    end
  end

  assign md_busy = (r_md_q != '0);

  always_comb begin
    w_raw            = '0;
    w_raw[CAUSE_LW]  = w_lwstall;
    w_raw[CAUSE_BR]  = w_brstall;
    w_raw[CAUSE_MD]  = w_mdstall;
    w_raw[CAUSE_MEM] = w_memstall;
  end

  for (genvar gi = 0; gi < C_NUM_CAUSES; gi++) begin : g_cnt
    hz_sat_counter #(
      .W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (stat_clr),
      .inc   (w_raw[gi]),
      .count (w_cnt[gi])
    );
  end

  assign lw_cnt      = w_cnt[CAUSE_LW];
  assign br_cnt      = w_cnt[CAUSE_BR];
  assign md_cnt_stat = w_cnt[CAUSE_MD];
  assign mem_cnt     = w_cnt[CAUSE_MEM];

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
// ============================================================================
// tb_hazard_unit_mc : directed bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_unit_mc;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk;
  logic reset, branchD, mdopD, memtoregE, memtoregM;
  logic regwriteE, regwriteM, regwriteW;
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic mdstartE, memreqM, dmem_ready, stat_clr;
  logic [1:0] forwardAE, forwardBE;
  logic forwardAD, forwardBD, stallF, stallD, stallE, stallM, flushE, flushW, md_busy;
  logic [CNT_W-1:0] lw_cnt, br_cnt, md_cnt_stat, mem_cnt;

  hazard_unit_mc #(
    .REG_AW     (REG_AW),
    .MD_LATENCY (MD_LAT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .branchD(branchD), .mdopD(mdopD),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .mdstartE(mdstartE), .memreqM(memreqM), .dmem_ready(dmem_ready),
    .stat_clr(stat_clr),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushW(flushW), .md_busy(md_busy),
    .lw_cnt(lw_cnt), .br_cnt(br_cnt), .md_cnt_stat(md_cnt_stat), .mem_cnt(mem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_md_rem = 0;
  int m_cnt [4];
  bit chk_en = 0;

  function automatic int m_fwd(input logic [REG_AW-1:0] src);
    if (src != 0 && regwriteM && src == writeregM) return 2;
    if (src != 0 && regwriteW && src == writeregW) return 1;
    return 0;
  endfunction

  function automatic bit m_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic bit m_lw();
    return memtoregE && (m_hit(rtE, rsD) || m_hit(rtE, rtD));
  endfunction

  function automatic bit m_br();
    return branchD && ((regwriteE && (m_hit(writeregE, rsD) || m_hit(writeregE, rtD))) ||
                       (memtoregM && (m_hit(writeregM, rsD) || m_hit(writeregM, rtD))));
  endfunction

  function automatic bit m_mem();
    return memreqM && !dmem_ready;
  endfunction

  function automatic bit m_md();
    return mdopD && (m_md_rem > 0 || mdstartE);
  endfunction

  // {stallF, stallD, stallE, stallM, flushE, flushW}
  function automatic logic [5:0] m_stalls();
    if (reset) return 6'b000000;
    if (m_mem()) return 6'b111101;
    if (m_lw() || m_br() || m_md()) return 6'b110010;
    return 6'b000000;
  endfunction

  always @(posedge clk) begin
    bit raw [4];
    raw[0] = m_lw();
    raw[1] = m_br();
    raw[2] = m_md();
    raw[3] = m_mem();
    if (reset) begin
      m_md_rem = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      chk_en = 1;
    end else begin
      if (mdstartE && !raw[3]) m_md_rem = MD_LAT;
      else if (m_md_rem > 0) m_md_rem--;
      for (int i = 0; i < 4; i++) begin
        if (stat_clr) m_cnt[i] = 0;
        else if (raw[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("fwdAE", 32'(forwardAE), 32'(m_fwd(rsE)));
      check("fwdBE", 32'(forwardBE), 32'(m_fwd(rtE)));
      check("fwdAD", 32'(forwardAD), 32'(regwriteM && m_hit(rsD, writeregM)));
      check("fwdBD", 32'(forwardBD), 32'(regwriteM && m_hit(rtD, writeregM)));
      check("stalls", 32'({stallF, stallD, stallE, stallM, flushE, flushW}), 32'(m_stalls()));
      check("md_busy", 32'(md_busy), 32'(m_md_rem > 0));
      check("lw_cnt", 32'(lw_cnt), 32'(m_cnt[0]));
      check("br_cnt", 32'(br_cnt), 32'(m_cnt[1]));
      check("md_cnt", 32'(md_cnt_stat), 32'(m_cnt[2]));
      check("mem_cnt", 32'(mem_cnt), 32'(m_cnt[3]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    reset = 0; branchD = 0; mdopD = 0; memtoregE = 0; memtoregM = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    mdstartE = 0; memreqM = 0; dmem_ready = 1; stat_clr = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    mid();
    check("rst_md_busy", 32'(md_busy), 0);
    check("rst_lw_cnt", 32'(lw_cnt), 0);
    check("rst_mem_cnt", 32'(mem_cnt), 0);

    // forwarding priority and register-zero guard
    cyc(); idle();
    rsE = 3; rtE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    mid();
    check("lit_fwdAE_mem", 32'(forwardAE), 2);
    check("lit_fwdBE_mem", 32'(forwardBE), 2);
    cyc(); rsE = 0;
    mid();
    check("lit_fwdAE_r0", 32'(forwardAE), 0);
    cyc(); rsE = 3; regwriteM = 0;
    mid();
    check("lit_fwdAE_wb", 32'(forwardAE), 1);

    // load-use
    cyc(); idle(); stat_clr = 1;
    cyc(); idle(); memtoregE = 1; rtE = 5; rsD = 5;
    mid();
    check("lit_lw_stall", 32'({stallF, stallD, flushE, stallE}), 32'(4'b1110));
    cyc(); idle();
    mid();
    check("lit_lw_cnt1", 32'(lw_cnt), 1);
    cyc(); memtoregE = 1; rtE = 0; rsD = 0;
    mid();
    check("lit_lw_r0", 32'(stallF), 0);

    // branch stall then D-stage forward
    cyc(); idle(); branchD = 1; regwriteE = 1; writeregE = 7; rtD = 7;
    mid();
    check("lit_br_stall", 32'({stallD, flushE}), 32'(2'b11));
    cyc(); idle(); branchD = 1; rtD = 7; writeregM = 7; regwriteM = 1;
    mid();
    check("lit_br_fwd", 32'({forwardAD, forwardBD, stallD}), 32'(3'b010));
    check("lit_br_cnt", 32'(br_cnt), 1);

    // memory wait overlapping a load-use hazard
    cyc(); idle(); stat_clr = 1;
    cyc(); idle(); memreqM = 1; dmem_ready = 0; memtoregE = 1; rtE = 5; rsD = 5;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("lit_mem_stall", 32'({stallF, stallD, stallE, stallM, flushE, flushW}),
            32'(6'b111101));
      cyc();
    end
    idle();
    mid();
    check("lit_mem_release", 32'(stallM), 0);
    check("lit_mem_cnt", 32'(mem_cnt), 3);
    check("lit_lw_cnt3", 32'(lw_cnt), 3);

    // mult/div busy window
    cyc(); idle(); stat_clr = 1;
    cyc(); idle(); mdstartE = 1; mdopD = 1;
    mid();
    check("lit_md_t0", 32'({stallD, md_busy}), 32'(2'b10));
    for (int k = 1; k <= 5; k++) begin
      cyc(); mdstartE = 0;
      mid();
      check("lit_md_busy", 32'(md_busy), 32'(k <= MD_LAT));
      check("lit_md_stall", 32'(stallD), 32'(k <= MD_LAT));
    end
    check("lit_md_cnt_sat", 32'(md_cnt_stat), 3);

    // reset in the middle of a busy window with a pending memory wait
    cyc(); idle(); mdstartE = 1;
    cyc(); mdstartE = 0; mdopD = 1;
    mid();
    check("lit_rst_busy_pre", 32'(md_busy), 1);
    cyc(); reset = 1; memreqM = 1; dmem_ready = 0;
    mid();
    check("lit_rst_stalls", 32'({stallF, stallD, stallE, stallM, flushE, flushW}), 0);
    cyc(); idle(); mdopD = 1;
    mid();
    check("lit_rst_busy_post", 32'(md_busy), 0);

    // issue held by a memory wait must not load the counter
    cyc(); idle(); mdstartE = 1; memreqM = 1; dmem_ready = 0;
    cyc();
    mid();
    check("lit_md_held", 32'(md_busy), 0);
    cyc(); memreqM = 0; dmem_ready = 1;
    mid();
    check("lit_md_held2", 32'(md_busy), 0);
    cyc(); idle();
    mid();
    check("lit_md_loaded", 32'(md_busy), 1);

    // saturation and clear-over-increment
    cyc(); idle(); stat_clr = 1;
    cyc(); idle(); memtoregE = 1; rtE = 5; rtD = 5;
    repeat (5) cyc();
    stat_clr = 1;
    mid();
    check("lit_lw_sat", 32'(lw_cnt), 3);
    cyc(); idle();
    mid();
    check("lit_lw_clr", 32'(lw_cnt), 0);

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
